// File: rtl/ram_hidden_reader_pkg.sv
// Shared types and default sizes for the hidden-unit weight RAM reader and its RAM instance.
package ram_hidden_reader_pkg;

  localparam int NN_DATA_WIDTH  = 8;
  localparam int NN_ADDR_WIDTH  = 15;
  localparam int NN_FIFO_DEPTH  = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/ram_hidden_reader_sync_fifo.sv
// First-word-fall-through FIFO: the head entry shows on pop_data the cycle after it is pushed.
// Push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo
  import ram_hidden_reader_pkg::*;
#(
  parameter int WIDTH = NN_DATA_WIDTH + 1,
  parameter int DEPTH = NN_FIFO_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == (PW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage is not reset; the consumer qualifies pop_data with empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ram_hidden_reader.sv
// Burst reader for the hidden-unit weight RAM: first word 3 cycles after start, then one word per cycle.
// Address issue is credit-gated on FIFO occupancy plus in-flight reads, so out_ready stalls never drop data.
module ram_hidden_reader
  import ram_hidden_reader_pkg::*;
#(
  parameter int DATA_WIDTH = NN_DATA_WIDTH,
  parameter int ADDR_WIDTH = NN_ADDR_WIDTH,
  parameter int FIFO_DEPTH = NN_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_data,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = (CW+1)'(FIFO_DEPTH);

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_WIDTH:0] remaining;
  logic [1:0]          inflight;
  logic                cap_vld;
  logic                cap_last;
  logic [CW-1:0]       fifo_count;
  logic                fifo_empty;
  logic                fifo_full;
  logic [DATA_WIDTH:0] fifo_dout;
  logic [CW:0]         credit_used;
  logic                issue;
  logic                push;
  logic                pop;
  logic                xfer_last;

  assign ram_we   = 1'b0;
  assign ram_data = '0;

  assign credit_used = {1'b0, fifo_count} + {{(CW-1){1'b0}}, inflight};
  assign issue       = (state == READ) && (remaining != '0) && !fifo_full
                       && (credit_used < DEPTH_L);

  // The RAM returns data one cycle after the issue cycle; cap_vld marks that return cycle.
  assign push      = cap_vld;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? '0 : fifo_dout[DATA_WIDTH-1:0];
  assign out_last  = !fifo_empty && fifo_dout[DATA_WIDTH];
  assign pop       = out_valid && out_ready;
  assign xfer_last = pop && out_last;

  sync_fifo #(
    .WIDTH (DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({cap_last, ram_q}),
    .pop       (pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ram_addr  <= '0;
      remaining <= '0;
      inflight  <= '0;
      cap_vld   <= 1'b0;
      cap_last  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cap_vld  <= issue;
      cap_last <= issue && (remaining == (ADDR_WIDTH+1)'(1));
      inflight <= inflight + 2'(issue) - 2'(push);
      if (state == IDLE && start && len != '0) begin
        ram_addr  <= base_addr;
        remaining <= len;
      end else if (issue) begin
        ram_addr  <= ram_addr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len == '0) ? DONE : READ;
      end
      READ: begin
        if (issue && remaining == (ADDR_WIDTH+1)'(1)) state_nxt = DRAIN;
      end
      DRAIN: begin
        // The last-tagged word is the final push, so its handshake leaves the FIFO empty.
        if (inflight == '0 && xfer_last) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      READ, DRAIN: busy = 1'b1;
      DONE:        done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

endmodule
